// File: rtl/ascon_pkg.sv
// Shared ASCON definitions: 320-bit state type, encrypt FSM states,
// round constants, linear-layer rotation amounts and a rotate helper.
// Optional build macro: ASCON_PAD_EN (adds the in-engine padding state).
package ascon_pkg;

  // S[0] is x0 ... S[4] is x4.
  typedef logic [4:0][63:0] state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABSORB,
    ST_EMIT,
    ST_PERM,
    ST_DONE
`ifdef ASCON_PAD_EN
    ,
    ST_PAD
`endif
  } fsm_e;

  // c_r = {4'hF - r, r}, r = 0..11.
  localparam logic [7:0] RC [12] = '{
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
  };

  // Two right-rotation amounts per state word for the linear layer.
  localparam int unsigned ROT [5][2] = '{
    '{19, 28}, '{61, 39}, '{1, 6}, '{10, 17}, '{7, 41}
  };

  function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_encrypt_seq_if.sv
// Handshake/bus bundle of the iterative ASCON encrypt engine.
// master = producer of state/plaintext, slave = the engine.
// Optional build macro: ASCON_PAD_EN (adds pt_nbytes / ct_nbytes).
interface ascon_encrypt_seq_if;
  logic        load_valid;
  logic        load_ready;
  logic [63:0] x0, x1, x2, x3, x4;
  logic        pt_valid;
  logic        pt_ready;
  logic [63:0] pt_data;
  logic        pt_last;
  logic        ct_valid;
  logic        ct_ready;
  logic [63:0] ct_data;
  logic        ct_last;
  logic        busy;
  logic        state_valid;
  logic [63:0] y0, y1, y2, y3, y4;
`ifdef ASCON_PAD_EN
  logic [3:0]  pt_nbytes;
  logic [3:0]  ct_nbytes;
`endif

  modport master (
    output load_valid, x0, x1, x2, x3, x4, pt_valid, pt_data, pt_last, ct_ready,
`ifdef ASCON_PAD_EN
    output pt_nbytes,
    input  ct_nbytes,
`endif
    input  load_ready, pt_ready, ct_valid, ct_data, ct_last, busy, state_valid,
    input  y0, y1, y2, y3, y4
  );

  modport slave (
    input  load_valid, x0, x1, x2, x3, x4, pt_valid, pt_data, pt_last, ct_ready,
`ifdef ASCON_PAD_EN
    input  pt_nbytes,
    output ct_nbytes,
`endif
    output load_ready, pt_ready, ct_valid, ct_data, ct_last, busy, state_valid,
    output y0, y1, y2, y3, y4
  );
endinterface

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant addition on x2, bit-sliced
// 5-bit substitution layer, then per-word linear diffusion.
module ascon_round
  import ascon_pkg::*;
(
  input  state_t     s_in,
  input  logic [7:0] rc,
  output state_t     s_out
);

  state_t a;
  state_t t;

  // Round function, evaluated step by step on a working copy.
  always_comb begin
    a    = s_in;
    a[2] = a[2] ^ {56'd0, rc};
    // substitution layer (bit-sliced chi with pre/post mixing)
    a[0] = a[0] ^ a[4];
    a[4] = a[4] ^ a[3];
    a[2] = a[2] ^ a[1];
    t[0] = ~a[0] & a[1];
    t[1] = ~a[1] & a[2];
    t[2] = ~a[2] & a[3];
    t[3] = ~a[3] & a[4];
    t[4] = ~a[4] & a[0];
    a[0] = a[0] ^ t[1];
    a[1] = a[1] ^ t[2];
    a[2] = a[2] ^ t[3];
    a[3] = a[3] ^ t[4];
    a[4] = a[4] ^ t[0];
    a[1] = a[1] ^ a[0];
    a[0] = a[0] ^ a[4];
    a[3] = a[3] ^ a[2];
    a[2] = ~a[2];
    // linear diffusion layer
    for (int i = 0; i < 5; i++) begin
      s_out[i] = a[i] ^ rotr(a[i], ROT[i][0]) ^ rotr(a[i], ROT[i][1]);
    end
  end

endmodule

// File: rtl/ascon_encrypt_seq.sv
// Iterative ASCON data-phase encryption: absorbs 64-bit plaintext blocks
// into S0, emits registered ciphertext, and runs p^NROUNDS between blocks
// one round per cycle through a single ascon_round instance.
// Optional build macro: ASCON_PAD_EN (partial last block + PAD state).
module ascon_encrypt_seq
  import ascon_pkg::*;
#(
  parameter int NROUNDS = 6
) (
  input logic               clk,
  input logic               rst_n,
  ascon_encrypt_seq_if.slave bus
);

  fsm_e        st, st_nxt;
  state_t      s, s_rnd;
  logic [3:0]  cnt;
  logic [63:0] ct_q;
  logic        last_q;
  logic        load_ready_c, pt_ready_c, ct_valid_c;
  logic [3:0]  rnd_idx;
  logic [7:0]  rc;
  logic        perm_end;
  logic [63:0] absorb_ct, absorb_s0;
`ifdef ASCON_PAD_EN
  logic [3:0]  nb_q;
  logic [3:0]  n_eff;
  logic [63:0] mask, pad_bit;
`endif

  assign perm_end = (cnt == 4'(NROUNDS - 1));
  assign rnd_idx  = 4'(12 - NROUNDS) + cnt;
  assign rc       = (rnd_idx < 4'd12) ? RC[rnd_idx] : 8'h00;

  ascon_round u_round (
    .s_in  (s),
    .rc    (rc),
    .s_out (s_rnd)
  );

  // Absorb datapath: ciphertext word and updated S0 for the offered block.
  always_comb begin
`ifdef ASCON_PAD_EN
    n_eff     = !bus.pt_last ? 4'd8 : ((bus.pt_nbytes > 4'd8) ? 4'd8 : bus.pt_nbytes);
    mask      = ~(64'hFFFF_FFFF_FFFF_FFFF >> {n_eff, 3'b000});
    pad_bit   = (n_eff == 4'd8) ? 64'h0 : (64'h80 << (7'd56 - {n_eff, 3'b000}));
    absorb_ct = (s[0] ^ bus.pt_data) & mask;
    absorb_s0 = s[0] ^ (bus.pt_data & mask) ^ pad_bit;
`else
    absorb_ct = s[0] ^ bus.pt_data;
    absorb_s0 = absorb_ct;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) st <= ST_IDLE;
    else        st <= st_nxt;
  end

  // FSM next-state and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path can leave it unassigned and infer a latch.
    st_nxt       = st;
    load_ready_c = 1'b0;
    pt_ready_c   = 1'b0;
    ct_valid_c   = 1'b0;
    case (st)
      ST_IDLE, ST_DONE: begin
        load_ready_c = 1'b1;
        if (bus.load_valid) st_nxt = ST_ABSORB;
      end
      ST_ABSORB: begin
        pt_ready_c = 1'b1;
        if (bus.pt_valid) st_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        ct_valid_c = 1'b1;
        if (bus.ct_ready) begin
`ifdef ASCON_PAD_EN
          // a full final block still needs p^b followed by the pad bit
          st_nxt = (!last_q || nb_q == 4'd8) ? ST_PERM : ST_DONE;
`else
          st_nxt = last_q ? ST_DONE : ST_PERM;
`endif
        end
      end
      ST_PERM: begin
        if (perm_end) begin
`ifdef ASCON_PAD_EN
          st_nxt = last_q ? ST_PAD : ST_ABSORB;
`else
          st_nxt = ST_ABSORB;
`endif
        end
      end
`ifdef ASCON_PAD_EN
      ST_PAD: st_nxt = ST_DONE;
`endif
      default: st_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers: state word, ciphertext, last flag, round counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the 320-bit state is a flop array, not a RAM, so it is reset to give y a defined value.
      s      <= '0;
      ct_q   <= '0;
      last_q <= 1'b0;
      cnt    <= '0;
`ifdef ASCON_PAD_EN
      nb_q   <= '0;
`endif
    end else begin
      case (st)
        ST_IDLE, ST_DONE: begin
          if (bus.load_valid) begin
            s[0] <= bus.x0;
            s[1] <= bus.x1;
            s[2] <= bus.x2;
            s[3] <= bus.x3;
            s[4] <= bus.x4;
          end
        end
        ST_ABSORB: begin
          if (bus.pt_valid) begin
            ct_q   <= absorb_ct;
            s[0]   <= absorb_s0;
            last_q <= bus.pt_last;
`ifdef ASCON_PAD_EN
            nb_q   <= n_eff;
`endif
          end
        end
        ST_EMIT: begin
          if (bus.ct_ready) cnt <= '0;
        end
        ST_PERM: begin
          s   <= s_rnd;
          cnt <= cnt + 4'd1;
        end
`ifdef ASCON_PAD_EN
        ST_PAD: s[0][63] <= ~s[0][63];
`endif
        default: ;
      endcase
    end
  end

  assign bus.load_ready  = load_ready_c;
  assign bus.pt_ready    = pt_ready_c;
  assign bus.ct_valid    = ct_valid_c;
  assign bus.busy        = ~load_ready_c;
  assign bus.state_valid = (st == ST_DONE);
  assign bus.ct_data     = ct_q;
  assign bus.ct_last     = last_q;
  assign bus.y0          = s[0];
  assign bus.y1          = s[1];
  assign bus.y2          = s[2];
  assign bus.y3          = s[3];
  assign bus.y4          = s[4];
`ifdef ASCON_PAD_EN
  assign bus.ct_nbytes   = nb_q;
`endif

endmodule

// File: tb/tb_ascon_encrypt_seq.sv
// Self-checking bench for ascon_encrypt_seq: directed vector table,
// randomized multi-block messages against a table-driven S-box model,
// backpressure, mid-permutation reset and (with ASCON_PAD_EN) padding.
module tb_ascon_encrypt_seq;

  localparam int NROUNDS = 6;
`ifdef ASCON_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  typedef logic [4:0][63:0] mst_t;
  typedef struct {
    logic [63:0] x0;
    logic [63:0] pt;
    logic [3:0]  n;
    logic [63:0] ct;
    logic [63:0] y0;
  } vec_t;

  // ASCON 5-bit S-box, input/output bit 4 = x0 ... bit 0 = x4.
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ascon_encrypt_seq_if bus ();

  ascon_encrypt_seq #(.NROUNDS(NROUNDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int failures = 0;
  int msg_id = 0;
  logic [63:0] msg_pt [8];
  vec_t tbl [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic string nm(input string s);
    return $sformatf("m%0d_%s", msg_id, s);
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v} >> n;
    return d[63:0];
  endfunction

  function automatic mst_t m_round(input mst_t s, input int r);
    mst_t o;
    logic [4:0] v;
    logic [7:0] c;
    c = 8'(((15 - r) << 4) | r);
    s[2] = s[2] ^ {56'd0, c};
    for (int i = 0; i < 64; i++) begin
      v = SBOX[{s[0][i], s[1][i], s[2][i], s[3][i], s[4][i]}];
      o[0][i] = v[4]; o[1][i] = v[3]; o[2][i] = v[2]; o[3][i] = v[1]; o[4][i] = v[0];
    end
    s[0] = o[0] ^ ror(o[0], 19) ^ ror(o[0], 28);
    s[1] = o[1] ^ ror(o[1], 61) ^ ror(o[1], 39);
    s[2] = o[2] ^ ror(o[2], 1)  ^ ror(o[2], 6);
    s[3] = o[3] ^ ror(o[3], 10) ^ ror(o[3], 17);
    s[4] = o[4] ^ ror(o[4], 7)  ^ ror(o[4], 41);
    return s;
  endfunction

  function automatic mst_t m_perm(input mst_t s);
    for (int r = 12 - NROUNDS; r < 12; r++) s = m_round(s, r);
    return s;
  endfunction

  function automatic logic [63:0] m_mask(input int n);
    logic [63:0] m;
    m = '0;
    for (int j = 0; j < n && j < 8; j++) m[63 - 8 * j -: 8] = 8'hFF;
    return m;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_load_ready"}, bus.load_ready, 1);
    check({tag, "_pt_ready"}, bus.pt_ready, 0);
    check({tag, "_ct_valid"}, bus.ct_valid, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_state_valid"}, bus.state_valid, 0);
    check({tag, "_ct_data"}, bus.ct_data, 0);
    check({tag, "_ct_last"}, bus.ct_last, 0);
    check({tag, "_y"}, bus.y0 | bus.y1 | bus.y2 | bus.y3 | bus.y4, 0);
  endtask

  task automatic do_load(input mst_t x);
    int k;
    k = 0;
    while (bus.load_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    check(nm("load_wait"), 64'(k < 200), 1);
    bus.x0 = x[0]; bus.x1 = x[1]; bus.x2 = x[2]; bus.x3 = x[3]; bus.x4 = x[4];
    bus.load_valid = 1'b1;
    @(posedge clk);
    #1 bus.load_valid = 1'b0;
  endtask

  task automatic drive_pt(input logic [63:0] pt, input logic last, input int n);
    int k;
    bus.pt_data  = pt;
    bus.pt_last  = last;
`ifdef ASCON_PAD_EN
    bus.pt_nbytes = 4'(n);
`endif
    bus.pt_valid = 1'b1;
    k = 0;
    while (bus.pt_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    check(nm("pt_wait"), 64'(k < 200), 1);
    @(posedge clk);
    #1 bus.pt_valid = 1'b0;
  endtask

  task automatic run_msg(input mst_t x, input int nblk, input logic [3:0] last_n,
                         input int stall_cyc, input bit has_exp,
                         input logic [63:0] exp_ct, input logic [63:0] exp_y0);
    mst_t ms, yv;
    logic [63:0] ect, mk;
    logic last;
    int n, k, exp_lat;
    bit stall_ok, full_pad;
    ms = x;
    do_load(x);
    for (int b = 0; b < nblk; b++) begin
      last = (b == nblk - 1);
      n = last ? int'(last_n) : 8;
      if (n > 8) n = 8;
      drive_pt(msg_pt[b], last, n);
      mk  = m_mask(n);
      ect = (ms[0] ^ msg_pt[b]) & mk;
      if (n < 8) begin
        ms[0] = ms[0] ^ (msg_pt[b] & mk);
        ms[0][63 - 8 * n] = ~ms[0][63 - 8 * n];
      end else begin
        ms[0] = ms[0] ^ msg_pt[b];
      end
      @(negedge clk);
      check(nm("ct_valid"), bus.ct_valid, 1);
      check(nm("ct_data"), bus.ct_data, ect);
      check(nm("ct_last"), bus.ct_last, last);
      if (has_exp) check(nm("tbl_ct"), bus.ct_data, exp_ct);
`ifdef ASCON_PAD_EN
      check(nm("ct_nbytes"), bus.ct_nbytes, n);
`endif
      if (b == 0 && stall_cyc > 0) begin
        // a load request while emitting must be ignored
        bus.x0 = ~x[0]; bus.x1 = ~x[1]; bus.load_valid = 1'b1;
        stall_ok = 1'b1;
        repeat (stall_cyc) begin
          @(negedge clk);
          if (bus.ct_valid !== 1'b1 || bus.ct_data !== ect || bus.pt_ready !== 1'b0) stall_ok = 1'b0;
        end
        bus.load_valid = 1'b0;
        check(nm("stall_hold"), 64'(stall_ok), 1);
      end
      bus.ct_ready = 1'b1;
      @(posedge clk);
      #1 bus.ct_ready = 1'b0;
      full_pad = PAD_EN && last && n == 8;
      if (!last || full_pad) ms = m_perm(ms);
      if (full_pad) ms[0][63] = ~ms[0][63];
      exp_lat = !last ? NROUNDS + 1 : (full_pad ? NROUNDS + 2 : 1);
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while ((!last ? bus.pt_ready !== 1'b1 : bus.state_valid !== 1'b1) && k < 200);
      check(nm("latency"), k, exp_lat);
    end
    check(nm("busy_done"), bus.busy, 0);
    check(nm("state_valid"), bus.state_valid, 1);
    yv = {bus.y4, bus.y3, bus.y2, bus.y1, bus.y0};
    for (int i = 0; i < 5; i++) check(nm($sformatf("y%0d", i)), yv[i], ms[i]);
    if (has_exp) check(nm("tbl_y0"), bus.y0, exp_y0);
    msg_id++;
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mst_t x;
    int nb;
    bus.load_valid = 0; bus.pt_valid = 0; bus.ct_ready = 0; bus.pt_last = 0;
    bus.pt_data = '0; bus.x0 = '0; bus.x1 = '0; bus.x2 = '0; bus.x3 = '0; bus.x4 = '0;
`ifdef ASCON_PAD_EN
    bus.pt_nbytes = '0;
`endif

    // reset state
    #3;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // directed single-block vectors: {x0, pt, last nbytes, ct, y0}
    tbl.push_back('{64'h0, 64'h0, 4'd8, 64'h0, 64'h0});
    tbl.push_back('{64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd8,
                    64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210});
    tbl.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd8, 64'h0, 64'h0});
    tbl.push_back('{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 4'd8,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF});
`ifdef ASCON_PAD_EN
    tbl.push_back('{64'h0, 64'hAABB_CC00_0000_0000, 4'd3,
                    64'hAABB_CC00_0000_0000, 64'hAABB_CC80_0000_0000});
    tbl.push_back('{64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0000, 4'd0,
                    64'h0, 64'h9234_5678_9ABC_DEF0});
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      x = '0;
      x[0] = tbl[i].x0;
      if (i > 0) for (int j = 1; j < 5; j++) x[j] = r64();
      msg_pt[0] = tbl[i].pt;
      run_msg(x, 1, tbl[i].n, 0, 1'b1, tbl[i].ct, tbl[i].y0);
    end

    // randomized multi-block messages; the first one is stalled 20 cycles
    for (int m = 0; m < 6; m++) begin
      for (int j = 0; j < 5; j++) x[j] = r64();
      nb = int'($urandom_range(2, 4));
      for (int b = 0; b < nb; b++) msg_pt[b] = r64();
      run_msg(x, nb, PAD_EN ? 4'($urandom_range(0, 8)) : 4'd8,
              (m == 0) ? 20 : 0, 1'b0, '0, '0);
    end

`ifdef ASCON_PAD_EN
    // full final block: extra permutation then pad before DONE
    for (int j = 0; j < 5; j++) x[j] = r64();
    msg_pt[0] = r64(); msg_pt[1] = r64();
    run_msg(x, 2, 4'd8, 0, 1'b0, '0, '0);
`endif

    // reset in the middle of the permutation (after 3 rounds)
    for (int j = 0; j < 5; j++) x[j] = r64();
    do_load(x);
    drive_pt(r64(), 1'b0, 8);
    @(negedge clk);
    bus.ct_ready = 1'b1;
    @(posedge clk);
    #1 bus.ct_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("abort_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    msg_id = 100;
    for (int j = 0; j < 5; j++) x[j] = r64();
    msg_pt[0] = r64(); msg_pt[1] = r64();
    run_msg(x, 2, 4'd8, 0, 1'b0, '0, '0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ascon_encrypt_seq.md
Name: ascon_encrypt_seq

Overview:
- Iterative ASCON data-phase encryption engine.
- Counterpart of the combinational decrypt datapath. Takes the post-initialisation/AD 320-bit state, absorbs a stream of 64-bit plaintext blocks and emits 64-bit ciphertext blocks.
- Applies p^b between blocks, one round per cycle, through a single shared round unit.
- Hands the final state to the finalisation stage.

Parameters:
- NROUNDS, 6, rounds applied between blocks (legal 1..12). Round index r runs 12-NROUNDS..11. Constant c_r = {(4'hF - r), r[3:0]}, giving 0x96,0x87,0x78,0x69,0x5A,0x4B for NROUNDS=6.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- load_valid  in  1  request to load a new state
- load_ready  out  1  high in IDLE and DONE
- x0,x1,x2,x3,x4  in  64 each  state in, sampled on load handshake
- pt_valid  in  1  plaintext block valid
- pt_ready  out  1  high only in ABSORB
- pt_data  in  64  plaintext block
- pt_last  in  1  final block of the message
- ct_valid  out  1  ciphertext block valid
- ct_ready  in  1  downstream accepts ciphertext
- ct_data  out  64  ciphertext block, registered
- ct_last  out  1  ct_data is the final block
- busy  out  1  high in any state other than IDLE/DONE
- state_valid  out  1  high in DONE
- y0,y1,y2,y3,y4  out  64 each  state registers; meaningful when state_valid=1

Behaviour:
- Reset (async, rst_n=0): FSM goes to IDLE. State regs, ct_data, round counter and flags are all zero. All valid/ready outputs are 0 except load_ready=1.
- States: IDLE, ABSORB, EMIT, PERM, DONE (+ PAD under the optional feature).
- IDLE/DONE: on load_valid&load_ready, S <= {x0..x4}, state_valid drops, go to ABSORB. load_valid in any other state is ignored.
- ABSORB: pt_ready=1. On pt_valid&pt_ready:
  - ct_data <= S0 ^ pt_data
  - S0 <= S0 ^ pt_data
  - ct_last <= pt_last
  - go to EMIT
- EMIT: ct_valid=1. ct_data is held stable until ct_ready.
  - On ct_ready with ct_last=0: round counter <= 0, go to PERM.
  - On ct_ready with ct_last=1: go to DONE. No permutation follows the last block.
- PERM: each cycle S <= round(S, c_(12-NROUNDS+cnt)), cnt++. After NROUNDS cycles, go to ABSORB.
- Round: constant added to S2, then the standard 5-bit chi-style substitution layer, then linear diffusion with rotation amounts:
  - S0: 19, 28
  - S1: 61, 39
  - S2: 1, 6
  - S3: 10, 17
  - S4: 7, 41
- Latency:
  - pt handshake -> ct_valid on the next cycle.
  - ct handshake -> pt_ready after NROUNDS+1 cycles.
  - Minimum NROUNDS+2 cycles per block.
- DONE: y0..y4 = S, state_valid=1, held until the next load.
- Backpressure: ct_ready low stalls EMIT indefinitely; S does not change.
- Reset mid-operation: immediate abort to IDLE. The partial ciphertext stream is discarded; no ct_last is issued.

Optional Feature:
- Macro ASCON_PAD_EN.
- Enabled:
  - Adds input pt_nbytes[3:0] (0..8) and output ct_nbytes[3:0].
  - On non-last blocks, pt_nbytes is treated as 8.
  - Last block with n<8, where M keeps the top n bytes (big-endian):
    - ct_data = (S0^pt_data)&M, with low bytes zero
    - S0 <= (S0^(pt_data&M)) ^ (64'h80 << (56-8n))
    - ct_nbytes = n
  - Last block with n=8: after EMIT, run PERM, then PAD for one cycle (S0 ^= 64'h8000_0000_0000_0000), then DONE.
  - n=0: a ct block is emitted with data 0 and ct_nbytes 0.
- Disabled: every block is full; the caller pads. Ports pt_nbytes and ct_nbytes are absent.

Decomposition:
- Package ascon_pkg holds:
  - state typedef (5 x 64)
  - FSM enum
  - 12-entry round-constant array
  - rotation-amount constants
- Sub-module ascon_round: combinational single round (state in, rc in, state out), shared with future iterative blocks.

Test Plan:
- Reset check: load x0..x4 = all zero, pt=64'h0 last -> ct=64'h0, ct_last=1, DONE with y equal to the loaded state.
- Single-block XOR: x0=64'h0123_4567_89AB_CDEF, pt=64'hFFFF_FFFF_FFFF_FFFF, last -> ct=64'hFEDC_BA98_7654_3210; no PERM cycles (busy deasserts 2 cycles after the pt handshake).
- Two blocks, compared against a reference model:
  - ct1 = p6(S with S0=ct0).S0 ^ pt1, matching the combinational decrypt pair round-trip: decrypt(ct0,ct1) returns pt0,pt1.
  - State equality is checked before the final permutation.
- Backpressure: hold ct_ready=0 for 20 cycles -> ct_data stable, pt_ready=0, no S change; release -> PERM takes exactly 6 cycles.
- Reset mid-PERM (cnt=3): rst_n low -> all outputs at reset values asynchronously; a new load proceeds normally.
- ASCON_PAD_EN on: last n=3, x0=0 with pt=64'hAABBCC0000000000 -> ct=64'hAABBCC0000000000, S0=64'hAABBCC8000000000. Last n=8 -> extra PERM then PAD are observed before DONE.
